// File: rtl/div_sequencer_if.sv
// div_sequencer_if: divide request/result bus; master=pipeline drives reqValid/divOp/rv64/ia/ib/flush, slave=divider drives hold/outValid/result
interface div_sequencer_if #(parameter int XLEN = 64);
  logic reqValid;
  logic [1:0] divOp;
  logic rv64;
  logic [XLEN-1:0] ia;
  logic [XLEN-1:0] ib;
  logic flush;
  logic hold;
  logic outValid;
  logic [XLEN-1:0] result;
  modport master(output reqValid, divOp, rv64, ia, ib, flush, input hold, outValid, result);
  modport slave(input reqValid, divOp, rv64, ia, ib, flush, output hold, outValid, result);
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: iterative RV64M DIV/DIVU/REM/REMU(+W) unit, radix-2^BPC restoring; ports clk, rst (async active-low), bus (slave: request in, hold/outValid/result out)
module div_sequencer #(
  parameter int XLEN = 64,
  parameter int BPC = 1
) (
  input logic clk,
  input logic rst,
  div_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [XLEN-1:0] quo, rem, dsr, resultQ;
  logic isRem, w, negQ, negR, validQ;
  logic sgn, sa, sb, divZero, ovf;
  logic [XLEN-1:0] a, b, magA, magB, specRaw, specW, qn, rn, qRes, rRes, fin, finW;
  logic [XLEN:0] t;
  // W variants operate on the low word, extended per signedness, so one 64-bit datapath serves both widths
  assign sgn = ~bus.divOp[0];
  assign a = bus.rv64 ? (sgn ? {{32{bus.ia[31]}}, bus.ia[31:0]} : {32'b0, bus.ia[31:0]}) : bus.ia;
  assign b = bus.rv64 ? (sgn ? {{32{bus.ib[31]}}, bus.ib[31:0]} : {32'b0, bus.ib[31:0]}) : bus.ib;
  assign sa = sgn & a[63];
  assign sb = sgn & b[63];
  assign magA = sa ? -a : a;
  assign magB = sb ? -b : b;
  assign divZero = b == '0;
  assign ovf = sgn & (a == (bus.rv64 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) & (b == '1);
  assign specRaw = divZero ? (bus.divOp[1] ? a : '1) : (bus.divOp[1] ? '0 : a);
  assign specW = bus.rv64 ? {{32{specRaw[31]}}, specRaw[31:0]} : specRaw;
  always_comb begin
    qn = quo;
    rn = rem;
    t = '0;
    for (int i = 0; i < BPC; i++) begin
      t = {rn, qn[63]};
      qn = {qn[62:0], 1'b0};
      if (t >= {1'b0, dsr}) begin
        t = t - {1'b0, dsr};
        qn[0] = 1'b1;
      end
      rn = t[63:0];
    end
  end
  assign qRes = negQ ? -qn : qn;
  assign rRes = negR ? -rn : rn;
  assign fin = isRem ? rRes : qRes;
  assign finW = w ? {{32{fin[31]}}, fin[31:0]} : fin;
  assign bus.hold = ((state == IDLE & bus.reqValid) | state == BUSY) & ~bus.flush;
  assign bus.outValid = validQ;
  assign bus.result = resultQ;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      resultQ <= '0;
      isRem <= 1'b0;
      w <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      validQ <= 1'b0;
    end else begin
      validQ <= 1'b0;
      if (bus.flush) state <= IDLE;
      else case (state)
        IDLE: if (bus.reqValid) begin
          isRem <= bus.divOp[1];
          w <= bus.rv64;
          negQ <= sa ^ sb;
          negR <= sa;
          // left-align the 32-bit dividend so 32 shifts leave the quotient in the low word
          quo <= bus.rv64 ? {magA[31:0], 32'b0} : magA;
          rem <= '0;
          dsr <= magB;
          if (divZero | ovf) begin
            state <= DONE;
            resultQ <= specW;
            validQ <= 1'b1;
          end else begin
            state <= BUSY;
            cnt <= bus.rv64 ? 6'(32 / BPC - 1) : 6'(64 / BPC - 1);
          end
        end
        BUSY: begin
          quo <= qn;
          rem <= rn;
          if (cnt == '0) begin
            state <= DONE;
            resultQ <= finW;
            validQ <= 1'b1;
          end else cnt <= cnt - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
